// File: rtl/store_drain_queue.sv
// store_drain_queue: in-order buffer between commit and data memory.
// Committed stores are lane-formatted on entry, held in a small circular
// FIFO, and written out one at a time over a req/ack handshake.
//
// Handshakes:
//   commit side: a store is taken on a rising edge when store_enable,
//     ready and the mode/alignment is legal are all high. ready depends
//     only on the registered occupancy, so a pop in the same cycle does
//     not open a slot early.
//   memory side: mem_req with mem_addr/mem_wdata/mem_wstrb is held
//     steady until a cycle in which mem_ack is high. The write completes
//     on that edge. After each write the drain FSM spends one idle cycle
//     before it raises the next request.
module store_drain_queue #(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        store_enable,
    input  logic [2:0]  store_mode,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    output logic        ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] load_check_addr,
    output logic        load_conflict,
    output logic        misaligned,
    output logic        overflow,
    output logic        empty
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [DEPTH_LOG:0]   COUNT_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG-1:0] PTR_ONE   = {{(DEPTH_LOG-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG:0]   COUNT_MAX = DEPTH[DEPTH_LOG:0];

    // Entry storage: word address, byte strobes, lane-replicated data.
    logic [29:0] ent_addr_q [DEPTH];
    logic [3:0]  ent_strb_q [DEPTH];
    logic [31:0] ent_data_q [DEPTH];

    logic [DEPTH_LOG-1:0] head_q, head_d;
    logic [DEPTH_LOG-1:0] tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    state_t               state_q, state_d;
    logic                 misaligned_q, misaligned_d;
    logic                 overflow_q, overflow_d;

    logic        legal;
    logic [3:0]  new_strb;
    logic [31:0] new_data;
    logic        enq;
    logic        pop;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH_LOG-1:0] slot_off;

    // Decode the funct3 store size into legality, strobes and replicated data.
    always_comb begin
        legal    = 1'b0;
        new_strb = 4'b0000;
        new_data = 32'h0;
        case (store_mode)
            3'b000: begin
                legal    = 1'b1;
                new_strb = 4'b0001 << store_addr[1:0];
                new_data = {4{store_data[7:0]}};
            end
            3'b001: begin
                legal    = ~store_addr[0];
                new_strb = 4'b0011 << store_addr[1:0];
                new_data = {2{store_data[15:0]}};
            end
            3'b010: begin
                legal    = (store_addr[1:0] == 2'b00);
                new_strb = 4'b1111;
                new_data = store_data;
            end
            default: ;
        endcase
    end

    assign ready = (count_q < COUNT_MAX);
    assign enq   = store_enable && ready && legal;
    assign pop   = (state_q == S_REQ) && mem_ack;

    // Pointer, occupancy, flag and drain-FSM next-state logic.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        state_d      = state_q;
        misaligned_d = store_enable && !legal;
        overflow_d   = overflow_q || (store_enable && !ready);

        if (enq) tail_d = tail_q + PTR_ONE;
        if (pop) head_d = head_q + PTR_ONE;

        case ({enq, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: if (count_q != '0) state_d = S_REQ;
            S_REQ:  if (mem_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers; reset discards every entry and any in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            misaligned_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            misaligned_q <= misaligned_d;
            overflow_q   <= overflow_d;
        end
    end

    // Entry storage is pure datapath; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            ent_addr_q[tail_q] <= store_addr[31:2];
            ent_strb_q[tail_q] <= new_strb;
            ent_data_q[tail_q] <= new_data;
        end
    end

    // Word-match of the load against every occupied slot (head included).
    always_comb begin
        load_conflict = 1'b0;
        entry_valid   = '0;
        slot_off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off       = DEPTH_LOG'(i) - head_q;
            entry_valid[i] = ({1'b0, slot_off} < count_q);
            if (entry_valid[i] && (ent_addr_q[i] == load_check_addr[31:2]))
                load_conflict = 1'b1;
        end
    end

    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = mem_req ? {ent_addr_q[head_q], 2'b00} : 32'h0;
    assign mem_wdata  = mem_req ? ent_data_q[head_q] : 32'h0;
    assign mem_wstrb  = mem_req ? ent_strb_q[head_q] : 4'h0;
    assign misaligned = misaligned_q;
    assign overflow   = overflow_q;
    assign empty      = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_store_drain_queue.sv
// Bench for store_drain_queue: directed stores, expected memory writes in
// a scoreboard queue, and a monitor that checks every acked write.
module tb_store_drain_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        store_enable;
    logic [2:0]  store_mode;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] load_check_addr;
    logic        load_conflict;
    logic        misaligned;
    logic        overflow;
    logic        empty;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {addr[31:0], wdata[31:0], wstrb[3:0]}
    logic [67:0] exp_q[$];

    localparam logic [2:0] M_SB = 3'b000;
    localparam logic [2:0] M_SH = 3'b001;
    localparam logic [2:0] M_SW = 3'b010;

    store_drain_queue #(.DEPTH(4), .DEPTH_LOG(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .store_enable    (store_enable),
        .store_mode      (store_mode),
        .store_addr      (store_addr),
        .store_data      (store_data),
        .ready           (ready),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_ack         (mem_ack),
        .load_check_addr (load_check_addr),
        .load_conflict   (load_conflict),
        .misaligned      (misaligned),
        .overflow        (overflow),
        .empty           (empty)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        exp_q.push_back({addr, data, strb});
    endtask

    // Present one store for exactly one rising edge.
    task automatic send_store(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] data);
        store_enable = 1'b1;
        store_mode   = mode;
        store_addr   = addr;
        store_data   = data;
        tick();
        store_enable = 1'b0;
    endtask

    // Wait (bounded) until the queue reports empty, then realign to posedge+1.
    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (empty) begin
                done = 1'b1;
                break;
            end
        end
        check32(name, {31'h0, done}, 32'h1);
        tick();
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_stall = 1'b0;
    logic [67:0] prev_bus;

    always @(negedge clk) begin
        logic [67:0] exp;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_req && mem_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h strb %h, expected no write",
                             mem_addr, mem_wdata, mem_wstrb);
                end else begin
                    exp = exp_q.pop_front();
                    check32("wr_addr",  mem_addr,  exp[67:36]);
                    check32("wr_wdata", mem_wdata, exp[35:4]);
                    check32("wr_wstrb", {28'h0, mem_wstrb}, {28'h0, exp[3:0]});
                end
            end
            if (prev_stall) begin
                check32("stall_req",  {31'h0, mem_req}, 32'h1);
                check32("stall_bus_addr",  mem_addr,  prev_bus[67:36]);
                check32("stall_bus_wdata", mem_wdata, prev_bus[35:4]);
            end
            prev_stall = mem_req && !mem_ack;
            prev_bus   = {mem_addr, mem_wdata, mem_wstrb};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pat;
        bit         seen_req;

        rst             = 1'b1;
        store_enable    = 1'b0;
        store_mode      = 3'b000;
        store_addr      = 32'h0;
        store_data      = 32'h0;
        mem_ack         = 1'b0;
        load_check_addr = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check32("rst_ready",      {31'h0, ready},      32'h1);
        check32("rst_empty",      {31'h0, empty},      32'h1);
        check32("rst_mem_req",    {31'h0, mem_req},    32'h0);
        check32("rst_misaligned", {31'h0, misaligned}, 32'h0);
        check32("rst_overflow",   {31'h0, overflow},   32'h0);
        check32("rst_mem_addr",   mem_addr,            32'h0);
        check32("rst_mem_wdata",  mem_wdata,           32'h0);
        check32("rst_mem_wstrb",  {28'h0, mem_wstrb},  32'h0);
        tick();
        rst = 1'b0;

        // SW with ack held high: request two cycles after enable.
        mem_ack = 1'b1;
        push_exp(32'h100, 32'hDEADBEEF, 4'b1111);
        send_store(M_SW, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        check32("sw_lat_req_n1", {31'h0, mem_req}, 32'h0);
        check32("sw_lat_empty",  {31'h0, empty},   32'h0);
        tick();
        @(negedge clk);
        check32("sw_lat_req_n2", {31'h0, mem_req}, 32'h1);
        check32("sw_addr",  mem_addr,  32'h100);
        check32("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check32("sw_wstrb", {28'h0, mem_wstrb}, 32'hF);
        tick();
        @(negedge clk);
        check32("sw_empty_after", {31'h0, empty},   32'h1);
        check32("sw_req_after",   {31'h0, mem_req}, 32'h0);
        check32("sw_addr_idle",   mem_addr,         32'h0);
        tick();

        // Byte and half lane formatting.
        push_exp(32'h200, 32'hA5A5A5A5, 4'b1000);
        send_store(M_SB, 32'h203, 32'h000000A5);
        wait_idle("sb_drain");
        push_exp(32'h200, 32'h12341234, 4'b1100);
        send_store(M_SH, 32'h202, 32'hFFFF1234);
        wait_idle("sh_drain");
        push_exp(32'h100, 32'h7F7F7F7F, 4'b0010);
        send_store(M_SB, 32'h101, 32'h1234567F);
        wait_idle("sb1_drain");

        // Rejections: misaligned SH, misaligned SW, illegal mode.
        send_store(M_SH, 32'h101, 32'h1111);
        @(negedge clk);
        check32("rej_sh_mis", {31'h0, misaligned}, 32'h1);
        check32("rej_sh_empty", {31'h0, empty}, 32'h1);
        tick();
        @(negedge clk);
        check32("rej_sh_mis_clr", {31'h0, misaligned}, 32'h0);
        check32("rej_sh_req", {31'h0, mem_req}, 32'h0);
        tick();
        send_store(M_SW, 32'h102, 32'h2222);
        @(negedge clk);
        check32("rej_sw_mis", {31'h0, misaligned}, 32'h1);
        tick();
        @(negedge clk);
        check32("rej_sw_mis_clr", {31'h0, misaligned}, 32'h0);
        check32("rej_sw_empty", {31'h0, empty}, 32'h1);
        tick();
        send_store(3'b011, 32'h100, 32'h3333);
        @(negedge clk);
        check32("rej_mode_mis", {31'h0, misaligned}, 32'h1);
        tick();
        @(negedge clk);
        check32("rej_mode_mis_clr", {31'h0, misaligned}, 32'h0);
        check32("rej_mode_req", {31'h0, mem_req}, 32'h0);
        check32("rej_mode_empty", {31'h0, empty}, 32'h1);
        check32("rej_overflow", {31'h0, overflow}, 32'h0);
        tick();

        // Fill with ack low: five back-to-back SW, the fifth overflows.
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            store_enable = 1'b1;
            store_mode   = M_SW;
            store_addr   = 32'h400 + 32'(4 * i);
            store_data   = 32'h11110000 + 32'(i);
            @(negedge clk);
            check32($sformatf("fill_ready_%0d", i), {31'h0, ready}, (i < 4) ? 32'h1 : 32'h0);
            check32($sformatf("fill_ovf_%0d", i), {31'h0, overflow}, 32'h0);
            if (i < 4) push_exp(32'h400 + 32'(4 * i), 32'h11110000 + 32'(i), 4'b1111);
            tick();
        end
        store_enable = 1'b0;
        @(negedge clk);
        check32("full_overflow", {31'h0, overflow}, 32'h1);
        check32("full_ready",    {31'h0, ready},    32'h0);
        check32("full_head_addr", mem_addr, 32'h400);
        check32("full_head_data", mem_wdata, 32'h11110000);
        repeat (2) tick();
        mem_ack = 1'b1;
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[i] = mem_req;
            tick();
        end
        check32("drain_pattern", {24'h0, pat}, 32'h55);
        check32("drain_empty",   {31'h0, empty}, 32'h1);
        check32("ovf_sticky",    {31'h0, overflow}, 32'h1);

        // Load conflict against a buffered store.
        mem_ack         = 1'b0;
        load_check_addr = 32'h302;
        push_exp(32'h300, 32'hCAFEF00D, 4'b1111);
        send_store(M_SW, 32'h300, 32'hCAFEF00D);
        @(negedge clk);
        check32("lc_same_word", {31'h0, load_conflict}, 32'h1);
        tick();
        load_check_addr = 32'h304;
        @(negedge clk);
        check32("lc_next_word", {31'h0, load_conflict}, 32'h0);
        tick();
        load_check_addr = 32'h300;
        mem_ack         = 1'b1;
        @(negedge clk);
        check32("lc_ack_cycle", {31'h0, load_conflict}, 32'h1);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        check32("lc_after_ack", {31'h0, load_conflict}, 32'h0);
        tick();

        // A store being enqueued this cycle is not yet visible.
        load_check_addr = 32'h500;
        store_enable    = 1'b1;
        store_mode      = M_SW;
        store_addr      = 32'h500;
        store_data      = 32'h55555555;
        @(negedge clk);
        check32("lc_enq_cycle", {31'h0, load_conflict}, 32'h0);
        tick();
        store_enable = 1'b0;
        @(negedge clk);
        check32("lc_enq_next", {31'h0, load_conflict}, 32'h1);
        tick();

        // Reset with a write in flight and three entries queued.
        send_store(M_SW, 32'h504, 32'h66666666);
        send_store(M_SW, 32'h508, 32'h77777777);
        @(negedge clk);
        check32("prerst_req", {31'h0, mem_req}, 32'h1);
        tick();
        rst     = 1'b1;
        mem_ack = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check32("postrst_req",      {31'h0, mem_req},       32'h0);
        check32("postrst_empty",    {31'h0, empty},         32'h1);
        check32("postrst_ready",    {31'h0, ready},         32'h1);
        check32("postrst_overflow", {31'h0, overflow},      32'h0);
        check32("postrst_conflict", {31'h0, load_conflict}, 32'h0);
        tick();
        seen_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) seen_req = 1'b1;
            tick();
        end
        check32("postrst_no_writes", {31'h0, seen_req}, 32'h0);
        check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_drain_queue.md
Name: store_drain_queue

Overview:
- Sits directly downstream of the commit stage.
- Accepts at most one committed store per cycle (enable/mode/addr/data) and buffers it in an in-order FIFO.
- Drains the FIFO to data memory over a req/ack handshake with byte-lane strobes.
- Also reports back-pressure to commit, and flags pending-store word hazards to the load unit.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- DEPTH_LOG, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- store_enable  in  1  commit presents a store this cycle.
- store_mode  in  3  RISC-V funct3 for the store: 000 SB, 001 SH, 010 SW.
- store_addr  in  32  byte address.
- store_data  in  32  rs2 value; the store uses its low byte/half/word.
- ready  out  1  queue can accept a store this cycle.
- mem_req  out  1  write request to data memory.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-shifted write data.
- mem_wstrb  out  4  byte enables.
- mem_ack  in  1  memory accepted the write this cycle.
- load_check_addr  in  32  address of a load being issued.
- load_conflict  out  1  a buffered store targets the same word as the load.
- misaligned  out  1  one-cycle pulse: the last offered store was rejected.
- overflow  out  1  sticky: a store was offered while ready was low.
- empty  out  1  no buffered stores and no write in flight.

Behaviour:
- Reset values: count=0, head=0, tail=0, state=IDLE, mem_req=0, misaligned=0, overflow=0, ready=1, empty=1.
  - mem_addr, mem_wdata and mem_wstrb read 0 while mem_req=0.
- Reset mid-transaction:
  - Next cycle mem_req=0 and all entries are discarded.
  - An ack arriving in the reset cycle is ignored.
- Back-pressure: ready = (count < DEPTH), computed from registered count only. A dequeue in the same cycle does not free a slot early.
- Enqueue occurs when store_enable && ready && legal.
  - Entry stores: word address, wstrb, and shifted wdata.
  - tail advances modulo DEPTH; count increments.
- Legality and lane formatting:
  - SB: always legal. wstrb = 1<<addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: legal only if addr[0]==0. wstrb = 4'b0011<<addr[1:0]; wdata = {2{data[15:0]}}.
  - SW: legal only if addr[1:0]==0. wstrb = 4'b1111; wdata = data.
  - Any other mode, or a misaligned SH/SW, is not enqueued; misaligned=1 for the following cycle only.
- If store_enable && !ready: the store is dropped and overflow is set. overflow clears only on rst.
- Drain FSM has two states, IDLE and REQ.
  - IDLE: if count>0, go to REQ at the next edge.
  - REQ: mem_req=1; mem_addr/mem_wdata/mem_wstrb come from the head entry and stay stable until ack.
  - REQ with mem_ack=1: pop the head (head++ modulo DEPTH, count--) and return to IDLE. This gives one bubble cycle between consecutive writes.
  - REQ with mem_ack=0: remain in REQ, outputs unchanged.
  - mem_ack while in IDLE is ignored.
- Simultaneous enqueue and pop in one cycle: count is unchanged and both pointers advance. Pointer wrap-around must not corrupt the FIFO at count==DEPTH.
- Latency: a store enqueued at edge N gives the earliest mem_req=1 in the cycle after edge N+1.
- load_conflict is combinational: OR over all valid entries of (entry.addr[31:2] == load_check_addr[31:2]).
  - The head entry counts while in REQ, including the ack cycle.
  - A store being enqueued in the same cycle is not included.
- empty = (count==0) && (state==IDLE).

Test Plan:
- Reset, then SW addr=0x100 data=0xDEADBEEF with ack held 1 → mem_req high 2 cycles after enable; addr=0x100, wstrb=1111, wdata=DEADBEEF; empty returns to 1 after ack.
- SB addr=0x203 data=0x000000A5 → mem_addr=0x200, wstrb=1000, wdata=A5A5A5A5. SH addr=0x202 data=0x1234 → wstrb=1100, wdata=12341234.
- SH addr=0x101, SW addr=0x102, mode=011 → each rejected; misaligned pulses once per rejection; no mem_req; count stays 0.
- ack held 0; offer 5 consecutive SW → ready drops after 4 and overflow=1. Release ack → exactly 4 writes drain in FIFO order with one idle cycle between them.
- Buffer SW at 0x300; load_check_addr=0x302 → load_conflict=1. load_check_addr=0x304 → 0. After the ack of 0x300 → 0.
- Assert rst while mem_req=1 with 3 entries queued → next cycle mem_req=0, empty=1, ready=1; no further writes issue.
